// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the LEGv8 program loader.
// Holds the 4-bit op-select codes, the standard LEGv8 opcode constants,
// the field widths of each instruction format, the loader FSM state
// type and a small immediate range-check helper. The encoder and any
// decoder import this package, so the two cannot disagree on encodings.
package imem_loader_pkg;

  // Op-select codes presented on in_op
  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_ORR    = 4'd3,
    OP_ADDI   = 4'd4,
    OP_LDUR   = 4'd5,
    OP_LDURB  = 4'd6,
    OP_LDURH  = 4'd7,
    OP_LDURSW = 4'd8,
    OP_STUR   = 4'd9,
    OP_STURB  = 4'd10,
    OP_STURH  = 4'd11,
    OP_STURW  = 4'd12,
    OP_CBZ    = 4'd13,
    OP_CBNZ   = 4'd14,
    OP_B      = 4'd15
  } op_e;

  // Field widths
  localparam int R_OPC_W  = 11;
  localparam int I_OPC_W  = 10;
  localparam int D_OPC_W  = 11;
  localparam int CB_OPC_W = 8;
  localparam int B_OPC_W  = 6;
  localparam int IMM12_W  = 12;
  localparam int ADDR9_W  = 9;
  localparam int ADDR19_W = 19;
  localparam int ADDR26_W = 26;
  localparam int IMM_IN_W = 27;

  // R-format opcodes
  localparam logic [R_OPC_W-1:0]  OPC_ADD    = 11'b10001011000;
  localparam logic [R_OPC_W-1:0]  OPC_SUB    = 11'b11001011000;
  localparam logic [R_OPC_W-1:0]  OPC_AND    = 11'b10001010000;
  localparam logic [R_OPC_W-1:0]  OPC_ORR    = 11'b10101010000;
  // I-format opcode
  localparam logic [I_OPC_W-1:0]  OPC_ADDI   = 10'b1001000100;
  // D-format opcodes
  localparam logic [D_OPC_W-1:0]  OPC_LDUR   = 11'b11111000010;
  localparam logic [D_OPC_W-1:0]  OPC_STUR   = 11'b11111000000;
  localparam logic [D_OPC_W-1:0]  OPC_LDURB  = 11'b00111000010;
  localparam logic [D_OPC_W-1:0]  OPC_STURB  = 11'b00111000000;
  localparam logic [D_OPC_W-1:0]  OPC_LDURH  = 11'b01111000010;
  localparam logic [D_OPC_W-1:0]  OPC_STURH  = 11'b01111000000;
  localparam logic [D_OPC_W-1:0]  OPC_LDURSW = 11'b10111000100;
  localparam logic [D_OPC_W-1:0]  OPC_STURW  = 11'b10111000000;
  // CB-format opcodes
  localparam logic [CB_OPC_W-1:0] OPC_CBZ    = 8'b10110100;
  localparam logic [CB_OPC_W-1:0] OPC_CBNZ   = 8'b10110101;
  // B-format opcode
  localparam logic [B_OPC_W-1:0]  OPC_B      = 6'b000101;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DONE  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // True when the 27-bit two's-complement value fits in a signed field of
  // width w, i.e. every bit from w-1 upward equals the sign bit.
  function automatic logic fits_signed(input logic [IMM_IN_W-1:0] v, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < IMM_IN_W; i++) begin
      if (i >= w - 1 && v[i] != v[IMM_IN_W-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/insn_encoder.sv
// insn_encoder: combinational LEGv8 instruction encoder.
// Ports:
//   op_i       4-bit op select (op_e)
//   rd_i       Rd for R/I formats, Rt for D/CB formats
//   rn_i, rm_i source register fields
//   imm_i      27-bit two's-complement immediate (ADDI treated unsigned)
//   word_o     32-bit machine word
//   range_ok_o immediate fits the destination field of the selected format
module insn_encoder
  import imem_loader_pkg::*;
(
  input  logic [3:0]          op_i,
  input  logic [4:0]          rd_i,
  input  logic [4:0]          rn_i,
  input  logic [4:0]          rm_i,
  input  logic [IMM_IN_W-1:0] imm_i,
  output logic [31:0]         word_o,
  output logic                range_ok_o
);

  logic [R_OPC_W-1:0] r_opc;
  logic [D_OPC_W-1:0] d_opc;

  always_comb begin
    word_o     = '0;
    range_ok_o = 1'b1;
    r_opc      = OPC_ADD;
    d_opc      = OPC_LDUR;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        case (op_i)
          OP_SUB:  r_opc = OPC_SUB;
          OP_AND:  r_opc = OPC_AND;
          OP_ORR:  r_opc = OPC_ORR;
          default: r_opc = OPC_ADD;
        endcase
        // shamt is always zero for these ops
        word_o = {r_opc, rm_i, 6'b000000, rn_i, rd_i};
      end
      OP_ADDI: begin
        word_o     = {OPC_ADDI, imm_i[IMM12_W-1:0], rn_i, rd_i};
        // Unsigned: any bit above the 12-bit field (including sign) rejects
        range_ok_o = (imm_i[IMM_IN_W-1:IMM12_W] == '0);
      end
      OP_LDUR, OP_LDURB, OP_LDURH, OP_LDURSW,
      OP_STUR, OP_STURB, OP_STURH, OP_STURW: begin
        case (op_i)
          OP_LDURB:  d_opc = OPC_LDURB;
          OP_LDURH:  d_opc = OPC_LDURH;
          OP_LDURSW: d_opc = OPC_LDURSW;
          OP_STUR:   d_opc = OPC_STUR;
          OP_STURB:  d_opc = OPC_STURB;
          OP_STURH:  d_opc = OPC_STURH;
          OP_STURW:  d_opc = OPC_STURW;
          default:   d_opc = OPC_LDUR;
        endcase
        word_o     = {d_opc, imm_i[ADDR9_W-1:0], 2'b00, rn_i, rd_i};
        range_ok_o = fits_signed(imm_i, ADDR9_W);
      end
      OP_CBZ, OP_CBNZ: begin
        word_o     = {(op_i == OP_CBNZ) ? OPC_CBNZ : OPC_CBZ,
                      imm_i[ADDR19_W-1:0], rd_i};
        range_ok_o = fits_signed(imm_i, ADDR19_W);
      end
      default: begin // OP_B
        word_o     = {OPC_B, imm_i[ADDR26_W-1:0]};
        range_ok_o = fits_signed(imm_i, ADDR26_W);
      end
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Accepts symbolic LEGv8 instructions over a valid/ready stream, encodes
// them and writes the words to consecutive instruction-memory addresses
// from 0, holding the core in reset until the last word is written.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_op/rd/rn/rm/imm  symbolic instruction fields
//   in_last             final instruction of the program
//   imem_we/addr/wdata  registered instruction-memory write port
//   core_reset          processor held in reset while 1
//   done, error         program loaded / load aborted (sticky until reset)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rn,
  input  logic [4:0]            in_rm,
  input  logic [IMM_IN_W-1:0]   in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic                  core_reset_q;
  logic                  done_q;
  logic                  error_q;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        hs;
  logic        at_top;

  insn_encoder u_enc (
    .op_i       (in_op),
    .rd_i       (in_rd),
    .rn_i       (in_rn),
    .rm_i       (in_rm),
    .imm_i      (in_imm),
    .word_o     (enc_word),
    .range_ok_o (enc_ok)
  );

  // Gating with reset makes in_ready drop in the reset cycle itself and
  // rise in the first cycle after it.
  assign in_ready = (state_q == ST_LOAD) && !reset;
  assign hs       = in_valid && in_ready;
  assign at_top   = (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Status flags follow the state one cycle late, so the final write
      // lands before done/error are reported.
      done_q       <= (state_q == ST_DONE);
      error_q      <= (state_q == ST_ERROR);
      core_reset_q <= (state_q != ST_DONE);
      if (hs) begin
        if (!enc_ok) begin
          // A rejected request reports immediately; nothing is written.
          state_q <= ST_ERROR;
          error_q <= 1'b1;
        end else begin
          we_q    <= 1'b1;
          addr_q  <= cnt_q;
          wdata_q <= enc_word;
          cnt_q   <= cnt_q + 1'b1;
          if (in_last) begin
            state_q <= ST_DONE;
          end else if (at_top) begin
            // Memory full with more to come: never wrap onto address 0.
            state_q <= ST_ERROR;
          end
        end
      end
    end
  end

  // A write still pending when reset arrives is discarded.
  assign imem_we    = we_q && !reset;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [26:0] in_imm;
  logic        in_last;

  logic        in_ready, imem_we, core_reset, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  logic        in_ready2, imem_we2, core_reset2, done2, error2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .error(error)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we2),
    .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .core_reset(core_reset2), .done(done2), .error(error2)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    int          imm;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string nm, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rn, input logic [4:0] rm, input int imm,
                         input logic ok, input logic [31:0] word);
    vec_t v;
    v.name = nm; v.op = op; v.rd = rd; v.rn = rn; v.rm = rm;
    v.imm = imm; v.ok = ok; v.word = word;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0; in_imm = 27'd0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input int imm, input logic last);
    logic [31:0] imm32;
    imm32 = imm;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
    in_imm = imm32[26:0]; in_last = last;
  endtask

  // Holds reset for two edges, then releases it at posedge+1.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_word[4];
  int          exp_addr;
  logic        v;

  initial begin
    // Single-instruction vectors: name, op, rd, rn, rm, imm, in-range, word
    add_vec("ADD",        4'd0,  5'd1,  5'd2,  5'd3,  0,        1'b1, 32'h8B030041);
    add_vec("SUB",        4'd1,  5'd4,  5'd5,  5'd6,  0,        1'b1, 32'hCB0600A4);
    add_vec("AND",        4'd2,  5'd7,  5'd8,  5'd9,  0,        1'b1, 32'h8A090107);
    add_vec("ORR",        4'd3,  5'd10, 5'd11, 5'd12, 0,        1'b1, 32'hAA0C016A);
    add_vec("ADDI_4095",  4'd4,  5'd1,  5'd2,  5'd0,  4095,     1'b1, 32'h913FFC41);
    add_vec("ADDI_4096",  4'd4,  5'd1,  5'd2,  5'd0,  4096,     1'b0, 32'h0);
    add_vec("ADDI_neg",   4'd4,  5'd1,  5'd2,  5'd0,  -1,       1'b0, 32'h0);
    add_vec("STUR_255",   4'd9,  5'd1,  5'd2,  5'd0,  255,      1'b1, 32'hF80FF041);
    add_vec("STUR_256",   4'd9,  5'd1,  5'd2,  5'd0,  256,      1'b0, 32'h0);
    add_vec("LDURB_m256", 4'd6,  5'd3,  5'd4,  5'd0,  -256,     1'b1, 32'h38500083);
    add_vec("LDURB_m257", 4'd6,  5'd3,  5'd4,  5'd0,  -257,     1'b0, 32'h0);
    add_vec("LDURH",      4'd7,  5'd1,  5'd2,  5'd0,  0,        1'b1, 32'h78400041);
    add_vec("LDURSW",     4'd8,  5'd1,  5'd2,  5'd0,  1,        1'b1, 32'hB8801041);
    add_vec("STURB",      4'd10, 5'd1,  5'd2,  5'd0,  1,        1'b1, 32'h38001041);
    add_vec("STURH",      4'd11, 5'd1,  5'd2,  5'd0,  1,        1'b1, 32'h78001041);
    add_vec("STURW",      4'd12, 5'd1,  5'd2,  5'd0,  1,        1'b1, 32'hB8001041);
    add_vec("CBNZ_max",   4'd14, 5'd3,  5'd0,  5'd0,  262143,   1'b1, 32'hB57FFFE3);
    add_vec("CBZ_min",    4'd13, 5'd0,  5'd0,  5'd0,  -262144,  1'b1, 32'hB4800000);
    add_vec("CBZ_over",   4'd13, 5'd0,  5'd0,  5'd0,  262144,   1'b0, 32'h0);
    add_vec("B_max",      4'd15, 5'd0,  5'd0,  5'd0,  33554431, 1'b1, 32'h15FFFFFF);
    add_vec("B_min",      4'd15, 5'd0,  5'd0,  5'd0,  -33554432,1'b1, 32'h16000000);
    add_vec("B_over",     4'd15, 5'd0,  5'd0,  5'd0,  33554432, 1'b0, 32'h0);

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, sampled while reset is still high
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_we", imem_we, 1'b0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk1("rst_core_reset", core_reset, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst_in_ready_after", in_ready, 1'b1);
    $display("[TB] reset state checked");

    // Table-driven single-instruction vectors
    foreach (vq[i]) begin
      do_reset();
      drive(vq[i].op, vq[i].rd, vq[i].rn, vq[i].rm, vq[i].imm, 1'b0);
      step();
      idle();
      $display("[TB] vec %s we=%b addr=%0d data=%h err=%b", vq[i].name, imem_we,
               imem_addr, imem_wdata, error);
      chk1({vq[i].name, "_we"}, imem_we, vq[i].ok);
      chk1({vq[i].name, "_error"}, error, !vq[i].ok);
      if (vq[i].ok) begin
        chk({vq[i].name, "_addr"}, 32'(imem_addr), 32'h0);
        chk({vq[i].name, "_data"}, imem_wdata, vq[i].word);
        chk1({vq[i].name, "_ready"}, in_ready, 1'b1);
      end else begin
        chk1({vq[i].name, "_ready"}, in_ready, 1'b0);
        chk1({vq[i].name, "_core_reset"}, core_reset, 1'b1);
        step();
        chk1({vq[i].name, "_error_hold"}, error, 1'b1);
        chk1({vq[i].name, "_no_write"}, imem_we, 1'b0);
      end
    end

    // Back-to-back program ending with in_last
    stream_word[0] = 32'h91000529;
    stream_word[1] = 32'hF85F80C5;
    stream_word[2] = 32'hB4FFFFC0;
    stream_word[3] = 32'h17FFFFFF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(4'd4, 5'd9, 5'd9, 5'd0, 1, 1'b0);
        1: drive(4'd5, 5'd5, 5'd6, 5'd0, -8, 1'b0);
        2: drive(4'd13, 5'd0, 5'd0, 5'd0, -2, 1'b0);
        default: drive(4'd15, 5'd0, 5'd0, 5'd0, -1, 1'b1);
      endcase
      step();
      $display("[TB] stream %0d we=%b addr=%0d data=%h", i, imem_we, imem_addr, imem_wdata);
      chk1("stream_we", imem_we, 1'b1);
      chk("stream_addr", 32'(imem_addr), 32'(i));
      chk("stream_data", imem_wdata, stream_word[i]);
    end
    idle();
    chk1("stream_n1_ready", in_ready, 1'b0);
    chk1("stream_n1_done", done, 1'b0);
    chk1("stream_n1_core_reset", core_reset, 1'b1);
    step();
    chk1("stream_n2_we", imem_we, 1'b0);
    chk1("stream_n2_done", done, 1'b1);
    chk1("stream_n2_core_reset", core_reset, 1'b0);
    chk1("stream_n2_error", error, 1'b0);
    $display("[TB] stream done=%b core_reset=%b", done, core_reset);

    // Overflow on the 4-word instance with in_valid held high
    do_reset();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      $display("[TB] ovf %0d we=%b addr=%0d err=%b", i, imem_we2, imem_addr2, error2);
      chk1("ovf_we", imem_we2, 1'b1);
      chk("ovf_addr", 32'(imem_addr2), 32'(i));
      chk1("ovf_error_early", error2, 1'b0);
    end
    chk1("ovf_ready_n1", in_ready2, 1'b0);
    step();
    chk1("ovf_no_fifth_write", imem_we2, 1'b0);
    chk1("ovf_error", error2, 1'b1);
    chk1("ovf_core_reset", core_reset2, 1'b1);
    step();
    chk1("ovf_no_write_later", imem_we2, 1'b0);
    idle();

    // Reset during the cycle after a handshake drops the pending write
    do_reset();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    step();
    idle();
    reset = 1'b1;
    #1;
    $display("[TB] midreset we=%b", imem_we);
    chk1("midreset_we", imem_we, 1'b0);
    step();
    reset = 1'b0;
    #1;
    chk1("midreset_core_reset", core_reset, 1'b1);
    chk1("midreset_ready", in_ready, 1'b1);
    drive(4'd1, 5'd4, 5'd5, 5'd6, 0, 1'b0);
    step();
    idle();
    chk1("reload_we", imem_we, 1'b1);
    chk("reload_addr", 32'(imem_addr), 32'h0);
    chk("reload_data", imem_wdata, 32'hCB0600A4);

    // Random in_valid: writes only on handshakes, addresses sequential
    do_reset();
    exp_addr = 0;
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) drive(4'd0, 5'(i), 5'd0, 5'd0, 0, 1'b0);
      else idle();
      step();
      $display("[TB] rand %0d valid=%b we=%b addr=%0d", i, v, imem_we, imem_addr);
      chk1("rand_we", imem_we, v);
      if (v) begin
        chk("rand_addr", 32'(imem_addr), 32'(exp_addr));
        chk("rand_data", imem_wdata, 32'h8B000000 | 32'(i % 32));
        exp_addr++;
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
